// File: rtl/ajc_arith_arbiter_v_pkg.sv
// Shared definitions for the two-requester arithmetic arbiter:
// function codes, FSM states and the operand bundle.
package ajc_arith_defs_v;

  typedef enum logic [1:0] {
    FN_ADD  = 2'b00,
    FN_SUB  = 2'b01,
    FN_ADDK = 2'b10,
    FN_SUBK = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    func_e      func;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] k;
  } op_t;

  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } flags_t;

  function automatic logic [7:0] zext_k(input logic [1:0] k);
    return {6'b0, k};
  endfunction

endpackage

// File: rtl/ajc_8bit_arith_unit_v.sv
// Shared 8-bit add/subtract datapath with {C,N,V,Z} flags.
// Subtract is x + ~b + 1, so C reads as "no borrow".
module ajc_8bit_arith_unit_v
  import ajc_arith_defs_v::*;
(
  input  op_t        op,
  output logic [7:0] result,
  output flags_t     flags
);

  logic [7:0] opnd;
  logic       sub;
  logic [7:0] opnd_x;
  logic [8:0] sum;
  logic       ovf;

  always_comb begin
    opnd = op.y;
    sub  = 1'b0;
    unique case (op.func)
      FN_ADD: begin
        opnd = op.y;
        sub  = 1'b0;
      end
      FN_SUB: begin
        opnd = op.y;
        sub  = 1'b1;
      end
      FN_ADDK: begin
        opnd = zext_k(op.k);
        sub  = 1'b0;
      end
      FN_SUBK: begin
        opnd = zext_k(op.k);
        sub  = 1'b1;
      end
      default: begin
        opnd = op.y;
        sub  = 1'b0;
      end
    endcase
  end

  assign opnd_x = sub ? ~opnd : opnd;
  assign sum    = {1'b0, op.x} + {1'b0, opnd_x} + {8'b0, sub};
  assign result = sum[7:0];

  // Overflow: operands agree in sign, result does not.
  assign ovf = (op.x[7] == opnd_x[7]) && (sum[7] != op.x[7]);

  assign flags = {sum[8], sum[7], ovf, (sum[7:0] == 8'h00)};

endmodule

// File: rtl/ajc_arith_arbiter_v.sv
// Two-requester arbiter in front of one shared arithmetic unit.
// IDLE -> EXEC (grant) -> RESP (valid) -> IDLE, one op per 3 cycles.
module ajc_arith_arbiter_v
  import ajc_arith_defs_v::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req_A,
  input  logic       Req_B,
  input  logic [1:0] Func_A,
  input  logic [1:0] Func_B,
  input  logic [7:0] X_A,
  input  logic [7:0] X_B,
  input  logic [7:0] Y_A,
  input  logic [7:0] Y_B,
  input  logic [1:0] K_A,
  input  logic [1:0] K_B,
  output logic       Grant_A,
  output logic       Grant_B,
  output logic       Valid_A,
  output logic       Valid_B,
  output logic [7:0] Result,
  output logic [3:0] CNVZ,
  output logic       Busy
);

  state_e     state_q;
  state_e     state_d;
  op_t        op_q;
  op_t        win_op;
  logic       win_b;
  logic       owner_b_q;
  logic       last_b_q;
  logic       take;
  logic       capture;
  logic [7:0] result_q;
  flags_t     cnvz_q;
  logic [7:0] alu_res;
  flags_t     alu_flags;

  // Tie goes to the side not granted last, unless A is pinned.
  always_comb begin
    win_b = 1'b0;
    unique case (1'b1)
      (Req_A && Req_B):  win_b = !FIXED_PRIO && !last_b_q;
      (!Req_A && Req_B): win_b = 1'b1;
      default:           win_b = 1'b0;
    endcase
  end

  always_comb begin
    win_op.func = func_e'(Func_A);
    win_op.x    = X_A;
    win_op.y    = Y_A;
    win_op.k    = K_A;
    if (win_b) begin
      win_op.func = func_e'(Func_B);
      win_op.x    = X_B;
      win_op.y    = Y_B;
      win_op.k    = K_B;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    capture = 1'b0;
    Grant_A = 1'b0;
    Grant_B = 1'b0;
    Valid_A = 1'b0;
    Valid_B = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Req_A || Req_B) begin
          take    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        Grant_A = !owner_b_q;
        Grant_B = owner_b_q;
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        Valid_A = !owner_b_q;
        Valid_B = owner_b_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q      <= '0;
      owner_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      result_q  <= 8'h00;
      cnvz_q    <= '0;
    end else begin
      if (take) begin
        op_q      <= win_op;
        owner_b_q <= win_b;
        last_b_q  <= win_b;
      end
      if (capture) begin
        result_q <= alu_res;
        cnvz_q   <= alu_flags;
      end
    end
  end

  ajc_8bit_arith_unit_v u_alu (
    .op     (op_q),
    .result (alu_res),
    .flags  (alu_flags)
  );

  assign Result = result_q;
  assign CNVZ   = cnvz_q;
  assign Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ajc_arith_arbiter_v.sv
// Scoreboard bench: round-robin and fixed-priority instances share
// stimulus; a transaction-level model predicts grants and results.
module tb_ajc_arith_arbiter_v;

  logic       clk = 1'b0;
  logic       rst;
  logic       ra, rb;
  logic [1:0] fa, fb, ka, kb;
  logic [7:0] xa, xb, ya, yb;
  logic [1:0] ga, gb, va, vb, bsy;
  logic [1:0][7:0] res;
  logic [1:0][3:0] fl;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ajc_arith_arbiter_v #(.FIXED_PRIO(1'b0)) dut0 (
    .Clock(clk), .Reset(rst), .Req_A(ra), .Req_B(rb),
    .Func_A(fa), .Func_B(fb), .X_A(xa), .X_B(xb),
    .Y_A(ya), .Y_B(yb), .K_A(ka), .K_B(kb),
    .Grant_A(ga[0]), .Grant_B(gb[0]),
    .Valid_A(va[0]), .Valid_B(vb[0]),
    .Result(res[0]), .CNVZ(fl[0]), .Busy(bsy[0])
  );

  ajc_arith_arbiter_v #(.FIXED_PRIO(1'b1)) dut1 (
    .Clock(clk), .Reset(rst), .Req_A(ra), .Req_B(rb),
    .Func_A(fa), .Func_B(fb), .X_A(xa), .X_B(xb),
    .Y_A(ya), .Y_B(yb), .K_A(ka), .K_B(kb),
    .Grant_A(ga[1]), .Grant_B(gb[1]),
    .Valid_A(va[1]), .Valid_B(vb[1]),
    .Result(res[1]), .CNVZ(fl[1]), .Busy(bsy[1])
  );

  function automatic void chk(string nm, int p,
                              logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s inst%0d: got %0h expected %0h t=%0t",
               nm, p, act, exp, $time);
    end
  endfunction

  // Result and flags from plain integer arithmetic.
  function automatic logic [11:0] ref_op(input logic [1:0] fn,
    input logic [7:0] x, input logic [7:0] y, input logic [1:0] k);
    int xi, bi, full, sx, sb, sr;
    bit c, v;
    logic [7:0] r;
    xi = int'(x);
    bi = fn[1] ? int'(k) : int'(y);
    sx = (xi > 127) ? xi - 256 : xi;
    sb = (bi > 127) ? bi - 256 : bi;
    if (fn[0]) begin
      full = xi - bi; c = (xi >= bi); sr = sx - sb;
    end else begin
      full = xi + bi; c = (full > 255); sr = sx + sb;
    end
    r = 8'(full);
    v = (sr < -128) || (sr > 127);
    return {r, c, r[7], v, (r == 8'h00)};
  endfunction

  typedef struct {
    bit         own_b;
    int         acc;
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int         edge_n = 0;
  int         free_at[2] = '{0, 0};
  bit         last_b[2]  = '{1'b1, 1'b1};
  logic [7:0] held_r[2]  = '{8'h00, 8'h00};
  logic [3:0] held_f[2]  = '{4'h0, 4'h0};

  function automatic int qsize(input int p);
    if (p == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qfront(input int p);
    if (p == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpop(input int p);
    if (p == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void qflush(input int p);
    if (p == 0) q0.delete();
    else        q1.delete();
  endfunction

  // Reference model: an accepted request occupies the unit for 3 edges.
  initial forever begin
    @(posedge clk);
    edge_n++;
    for (int p = 0; p < 2; p++) begin
      bit prio;
      bit wb;
      exp_t e;
      logic [11:0] rr;
      prio = (p == 1);
      if (rst) begin
        qflush(p);
        free_at[p] = edge_n + 1;
        last_b[p]  = 1'b1;
        held_r[p]  = 8'h00;
        held_f[p]  = 4'h0;
      end else begin
        if (qsize(p) > 0) begin
          e = qfront(p);
          if (edge_n == e.acc + 1) begin
            held_r[p] = e.r;
            held_f[p] = e.f;
          end
        end
        if (edge_n >= free_at[p] && (ra || rb)) begin
          wb = rb && (!ra || (!prio && !last_b[p]));
          rr = wb ? ref_op(fb, xb, yb, kb) : ref_op(fa, xa, ya, ka);
          e.own_b = wb;
          e.acc   = edge_n;
          e.r     = rr[11:4];
          e.f     = rr[3:0];
          qpush(p, e);
          last_b[p]  = wb;
          free_at[p] = edge_n + 3;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard each cycle.
  initial forever begin
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bit has, eb, ega, egb;
      exp_t fr;
      has = (qsize(p) > 0);
      fr  = '{own_b: 1'b0, acc: -10, r: 8'h00, f: 4'h0};
      if (has) fr = qfront(p);
      eb  = has && (edge_n == fr.acc || edge_n == fr.acc + 1);
      ega = has && (edge_n == fr.acc) && !fr.own_b;
      egb = has && (edge_n == fr.acc) && fr.own_b;
      chk("busy", p, 32'(bsy[p]), 32'(eb));
      chk("result_hold", p, 32'(res[p]), 32'(held_r[p]));
      chk("cnvz_hold", p, 32'(fl[p]), 32'(held_f[p]));
      if (ga[p] || gb[p] || ega || egb)
        chk("grant", p, 32'({ga[p], gb[p]}), 32'({ega, egb}));
      if (va[p] || vb[p]) begin
        if (!has) begin
          chk("spurious_valid", p, 32'({va[p], vb[p]}), 32'h0);
        end else begin
          chk("valid_owner", p, 32'({va[p], vb[p]}),
              32'({!fr.own_b, fr.own_b}));
          chk("valid_latency", p, 32'(edge_n), 32'(fr.acc + 1));
          chk("result", p, 32'(res[p]), 32'(fr.r));
          chk("cnvz", p, 32'(fl[p]), 32'(fr.f));
          qpop(p);
        end
      end else if (has && edge_n >= fr.acc + 1) begin
        chk("missing_valid", p, 32'h0, 32'h1);
        qpop(p);
      end
    end
  end

  task automatic one_op(input bit use_b, input logic [1:0] fn,
    input logic [7:0] x, input logic [7:0] y, input logic [1:0] k,
    input logic [7:0] er, input logic [3:0] ef);
    if (use_b) begin
      rb = 1'b1; fb = fn; xb = x; yb = y; kb = k;
    end else begin
      ra = 1'b1; fa = fn; xa = x; ya = y; ka = k;
    end
    @(negedge clk);
    chk("d_grant", 0, 32'({ga[0], gb[0]}),
        use_b ? 32'h1 : 32'h2);
    ra = 1'b0;
    rb = 1'b0;
    @(negedge clk);
    chk("d_valid", 0, 32'({va[0], vb[0]}),
        use_b ? 32'h1 : 32'h2);
    chk("d_result", 0, 32'(res[0]), 32'(er));
    chk("d_cnvz", 0, 32'(fl[0]), 32'(ef));
    @(negedge clk);
  endtask

  initial begin
    int n0, n1;
    bit ord0[16];
    bit ord1[16];
    rst = 1'b1;
    ra = 1'b0; rb = 1'b0;
    fa = 2'b00; fb = 2'b00; ka = 2'b00; kb = 2'b00;
    xa = 8'h00; xb = 8'h00; ya = 8'h00; yb = 8'h00;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk("rst_grant", p, 32'({ga[p], gb[p]}), 32'h0);
      chk("rst_valid", p, 32'({va[p], vb[p]}), 32'h0);
      chk("rst_busy", p, 32'(bsy[p]), 32'h0);
      chk("rst_result", p, 32'(res[p]), 32'h0);
      chk("rst_cnvz", p, 32'(fl[p]), 32'h0);
    end
    rst = 1'b0;

    one_op(1'b0, 2'b00, 8'h7F, 8'h01, 2'b00, 8'h80, 4'b0110);
    one_op(1'b1, 2'b01, 8'h05, 8'h05, 2'b00, 8'h00, 4'b1001);
    one_op(1'b0, 2'b10, 8'hFF, 8'h00, 2'b01, 8'h00, 4'b1001);
    one_op(1'b1, 2'b11, 8'h00, 8'h00, 2'b11, 8'hFD, 4'b0100);

    // Both requesters held high straight after reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ra = 1'b1; rb = 1'b1;
    fa = 2'b00; xa = 8'h10; ya = 8'h20;
    fb = 2'b01; xb = 8'h30; yb = 8'h08;
    n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge clk);
      if ((ga[0] || gb[0]) && n0 < 16) begin ord0[n0] = gb[0]; n0++; end
      if ((ga[1] || gb[1]) && n1 < 16) begin ord1[n1] = gb[1]; n1++; end
    end
    ra = 1'b0; rb = 1'b0;
    chk("rr_count", 0, 32'(n0), 32'd4);
    chk("fixed_count", 1, 32'(n1), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", 0, 32'(ord0[i]), 32'(i % 2));
      chk("fixed_order", 1, 32'(ord1[i]), 32'h0);
    end
    repeat (4) @(negedge clk);

    // Reset while the operation is in EXEC.
    ra = 1'b1; fa = 2'b00; xa = 8'h7F; ya = 8'h01;
    @(negedge clk);
    chk("exec_grant", 0, 32'(ga[0]), 32'h1);
    ra = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec_busy", 0, 32'(bsy[0]), 32'h0);
    chk("rst_exec_result", 0, 32'(res[0]), 32'h0);
    repeat (3) begin
      chk("rst_exec_novalid", 0, 32'({va[0], vb[0]}), 32'h0);
      @(negedge clk);
    end

    // B pulsed only while A's operation is in EXEC.
    ra = 1'b1; fa = 2'b01; xa = 8'h40; ya = 8'h01;
    @(negedge clk);
    chk("ign_grant_a", 0, 32'(ga[0]), 32'h1);
    ra = 1'b0;
    rb = 1'b1;
    @(negedge clk);
    rb = 1'b0;
    repeat (4) begin
      chk("ign_grant_b", 0, 32'(gb[0]), 32'h0);
      chk("ign_grant_b", 1, 32'(gb[1]), 32'h0);
      @(negedge clk);
    end

    // Random traffic with occasional reset.
    repeat (4000) begin
      rst = ($urandom_range(0, 199) == 0);
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      fa  = 2'($urandom); fb = 2'($urandom);
      ka  = 2'($urandom); kb = 2'($urandom);
      xa  = 8'($urandom); xb = 8'($urandom);
      ya  = 8'($urandom); yb = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; ra = 1'b0; rb = 1'b0;
    repeat (6) @(negedge clk);
    for (int p = 0; p < 2; p++)
      chk("drain", p, 32'(qsize(p)), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
